// File: rtl/issue_queue_ctrl_pkg.sv
// issue_queue_ctrl_pkg: shared CPU types for the issue queue (entry layout, FSM states, widths)
package issue_queue_ctrl_pkg;
  localparam int PC_WIDTH = 17;
  localparam int INST_WIDTH = 32;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} iq_state_e;
  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   pc;
    logic                  br_pred;
    logic [PC_WIDTH-1:0]   jalr_pred;
  } iq_entry_t;
endpackage

// File: rtl/issue_queue_ctrl_if.sv
// issue_queue_ctrl_if: fetch-side push channel, decoder-side head channel and ROB flush
//   fetch_*        : instruction pushed by fetch, fetch_ready is the queue's accept
//   instruction_in : head entry valid, with instruction/pc/br_prediction/jalr_prediction
//   idle           : decoder consumes the head; flush: ROB clears the queue
//   master = fetch/decoder/ROB side, slave = the queue
interface issue_queue_ctrl_if;
  logic                                       fetch_valid;
  logic [issue_queue_ctrl_pkg::INST_WIDTH-1:0] fetch_inst;
  logic [issue_queue_ctrl_pkg::PC_WIDTH-1:0]   fetch_pc;
  logic                                       fetch_br_pred;
  logic [issue_queue_ctrl_pkg::PC_WIDTH-1:0]   fetch_jalr_pred;
  logic                                       fetch_ready;
  logic                                       instruction_in;
  logic [issue_queue_ctrl_pkg::INST_WIDTH-1:0] instruction;
  logic [issue_queue_ctrl_pkg::PC_WIDTH-1:0]   pc;
  logic                                       br_prediction;
  logic [issue_queue_ctrl_pkg::PC_WIDTH-1:0]   jalr_prediction;
  logic                                       idle;
  logic                                       flush;
  modport master (
    output fetch_valid, fetch_inst, fetch_pc, fetch_br_pred, fetch_jalr_pred, idle, flush,
    input  fetch_ready, instruction_in, instruction, pc, br_prediction, jalr_prediction
  );
  modport slave (
    input  fetch_valid, fetch_inst, fetch_pc, fetch_br_pred, fetch_jalr_pred, idle, flush,
    output fetch_ready, instruction_in, instruction, pc, br_prediction, jalr_prediction
  );
endinterface

// File: rtl/issue_queue_ctrl_ram.sv
// iq_entry_ram: DEPTH x 67-bit entry storage, one sync write port, one async read port
//   clk, we/waddr/wdata write; raddr/rdata combinational read; storage is never reset
module iq_entry_ram
  import issue_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  iq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output iq_entry_t     rdata
);
  iq_entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/issue_queue_ctrl.sv
// issue_queue_ctrl: in-order instruction queue between fetch and decode with ROB flush
//   clk, rst (async, active-high); bus: issue_queue_ctrl_if.slave; count: occupied entries
//   ISSUE_QUEUE_BYPASS_EN: when defined, an empty queue forwards fetch straight to the head
module issue_queue_ctrl
  import issue_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  issue_queue_ctrl_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  iq_state_e   state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        run, empty, push, pop, store, take;
  iq_entry_t   head, fetch_entry;
  assign run = state_q == RUN;
  assign empty = count_q == '0;
  assign fetch_entry = '{bus.fetch_inst, bus.fetch_pc, bus.fetch_br_pred, bus.fetch_jalr_pred};
  assign pop = run && !empty && bus.idle;
  assign bus.fetch_ready = run && (count_q < FULL || pop);
  assign push = bus.fetch_valid && bus.fetch_ready;
`ifdef ISSUE_QUEUE_BYPASS_EN
  // an empty queue hands fetch to the decoder directly; consumed entries are never stored
  assign take = run && empty && bus.fetch_valid && bus.idle;
  assign bus.instruction_in = run && (!empty || bus.fetch_valid);
  assign {bus.instruction, bus.pc, bus.br_prediction, bus.jalr_prediction} =
    (run && empty) ? fetch_entry : head;
`else
  assign take = 1'b0;
  assign bus.instruction_in = run && !empty;
  assign {bus.instruction, bus.pc, bus.br_prediction, bus.jalr_prediction} = head;
`endif
  assign store = push && !take;
  assign count = count_q;
  iq_entry_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (store && !bus.flush),
    .waddr (wr_ptr_q),
    .wdata (fetch_entry),
    .raddr (rd_ptr_q),
    .rdata (head)
  );
  // FLUSH lasts one cycle unless flush stays high; flush wipes any same-edge push/pop
  always_comb begin
    state_d  = bus.flush ? FLUSH : RUN;
    wr_ptr_d = bus.flush ? '0 : wr_ptr_q + (store ? AW'(1) : AW'(0));
    rd_ptr_d = bus.flush ? '0 : rd_ptr_q + (pop ? AW'(1) : AW'(0));
    count_d  = bus.flush ? '0 :
               (store && !pop) ? count_q + (AW+1)'(1) :
               (pop && !store) ? count_q - (AW+1)'(1) : count_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
endmodule
